// File: rtl/lz4_pkg.sv
// Shared types and constants for the LZ4 sequence parser.
package lz4_pkg;

  localparam int LEN_W = 16;
  localparam int LZ4_MINMATCH = 4;
  localparam logic [7:0] LZ4_EXT_BYTE = 8'hFF;
  localparam logic [3:0] NIB_EXT = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_LITEXT,
    ST_LIT,
    ST_OFFSET,
    ST_MATEXT,
    ST_CMD,
    ST_DONE,
    ST_ERR
  } lz4_state_e;

endpackage

// File: rtl/lz4_seq_parser_if.sv
// Parser-facing bundle: block control, shifter window, literal and match streams.
// lit_* and mat_* use valid/ready: a word moves on a cycle with valid && ready, and
// while valid is high without ready every payload field is held unchanged.
interface lz4_seq_parser_if;
  import lz4_pkg::*;

  logic             blk_start;
  logic [LEN_W-1:0] blk_size;
  logic [55:0]      win_data;
  logic [3:0]       win_remind;
  logic             shift_valid;
  logic [2:0]       in_shift;
  logic [31:0]      lit_data;
  logic [2:0]       lit_cnt;
  logic             lit_valid;
  logic             lit_ready;
  logic [LEN_W-1:0] mat_offset;
  logic [LEN_W-1:0] mat_len;
  logic             mat_valid;
  logic             mat_ready;
  logic             blk_done;
  logic             err;
  lz4_state_e       dbg_state;

  modport master (
    input  blk_start, blk_size, win_data, win_remind, lit_ready, mat_ready,
    output shift_valid, in_shift, lit_data, lit_cnt, lit_valid,
           mat_offset, mat_len, mat_valid, blk_done, err, dbg_state
  );

  modport slave (
    output blk_start, blk_size, win_data, win_remind, lit_ready, mat_ready,
    input  shift_valid, in_shift, lit_data, lit_cnt, lit_valid,
           mat_offset, mat_len, mat_valid, blk_done, err, dbg_state
  );
endinterface

// File: rtl/lz4_len_accum.sv
// Length accumulator: loads a token-derived base, adds extension bytes, counts down.
// ovf flags that adding the current extension byte would carry out of LEN_W.
module lz4_len_accum
  import lz4_pkg::*;
(
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             add,
  input  logic [7:0]       add_byte,
  input  logic             sub,
  input  logic [LEN_W-1:0] sub_val,
  output logic [LEN_W-1:0] acc,
  output logic             ovf
);
  logic [LEN_W:0] sum_ext;

  assign sum_ext = {1'b0, acc} + {{(LEN_W-7){1'b0}}, add_byte};
  assign ovf     = sum_ext[LEN_W];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)     acc <= '0;
    else if (load) acc <= load_val;
    else if (add)  acc <= sum_ext[LEN_W-1:0];
    else if (sub)  acc <= acc - sub_val;
  end
endmodule

// File: rtl/lz4_seq_parser.sv
// LZ4 sequence parser: walks token/extension/literal/offset fields from the shifter
// window, returns a per-cycle consume count and emits literal words and match commands.
module lz4_seq_parser
  import lz4_pkg::*;
(
  input logic              clk,
  input logic              rstN,
  lz4_seq_parser_if.master bus
);
  lz4_state_e       state;
  logic [LEN_W-1:0] blk_size_q, consumed, offset_q;
  logic [LEN_W-1:0] remaining, rem_after1, rem_after_k;
  logic [LEN_W-1:0] lit_acc, mat_acc;
  logic [3:0]       mnib, k4;
  logic [7:0]       byte0, byte1;
  logic [2:0]       k_now, k_eff, lit_k_q, shift_n;
  logic             lit_hold, lit_ovf, mat_ovf, lit_too_long, lit_xfer, done_q;

  assign byte0        = bus.win_data[55:48];
  assign byte1        = bus.win_data[47:40];
  assign remaining    = blk_size_q - consumed;
  assign rem_after1   = remaining - LEN_W'(1);
  assign rem_after_k  = remaining - LEN_W'(k_eff);
  assign lit_too_long = lit_acc > remaining;

  always_comb begin
    k4 = (lit_acc >= LEN_W'(4)) ? 4'd4 : lit_acc[3:0];
    if (bus.win_remind < k4) k4 = bus.win_remind;
  end
  assign k_now = k4[2:0];
  // Once a word is offered, its size is frozen until it transfers, even if the window grows.
  assign k_eff = lit_hold ? lit_k_q : k_now;

  assign bus.lit_valid = (state == ST_LIT) && !lit_too_long && (k_eff != 3'd0);
  assign bus.lit_cnt   = bus.lit_valid ? k_eff : 3'd0;
  assign lit_xfer      = bus.lit_valid && bus.lit_ready;

  always_comb begin
    case (bus.lit_cnt)
      3'd1:    bus.lit_data = {bus.win_data[55:48], 24'h0};
      3'd2:    bus.lit_data = {bus.win_data[55:40], 16'h0};
      3'd3:    bus.lit_data = {bus.win_data[55:32], 8'h0};
      3'd4:    bus.lit_data = bus.win_data[55:24];
      default: bus.lit_data = 32'h0;
    endcase
  end

  // Single-byte fields never reach past blk_size; the offset needs two in-block bytes.
  always_comb begin
    shift_n = 3'd0;
    case (state)
      ST_TOKEN, ST_LITEXT, ST_MATEXT:
        if (remaining != '0 && bus.win_remind >= 4'd1) shift_n = 3'd1;
      ST_OFFSET:
        if (remaining >= LEN_W'(2) && bus.win_remind >= 4'd2) shift_n = 3'd2;
      ST_LIT:
        if (lit_xfer) shift_n = k_eff;
      default: shift_n = 3'd0;
    endcase
  end
  assign bus.shift_valid = shift_n != 3'd0;
  assign bus.in_shift    = shift_n;

  assign bus.mat_valid  = state == ST_CMD;
  assign bus.mat_len    = mat_acc;
  assign bus.mat_offset = offset_q;
  assign bus.blk_done   = done_q;
  assign bus.err        = state == ST_ERR;
  assign bus.dbg_state  = state;

  lz4_len_accum u_lit_len (
    .clk(clk), .rstN(rstN),
    .load(state == ST_TOKEN && bus.shift_valid), .load_val(LEN_W'(byte0[7:4])),
    .add(state == ST_LITEXT && bus.shift_valid), .add_byte(byte0),
    .sub(lit_xfer), .sub_val(LEN_W'(k_eff)),
    .acc(lit_acc), .ovf(lit_ovf)
  );

  lz4_len_accum u_mat_len (
    .clk(clk), .rstN(rstN),
    .load(state == ST_TOKEN && bus.shift_valid),
    .load_val(LEN_W'(byte0[3:0]) + LEN_W'(LZ4_MINMATCH)),
    .add(state == ST_MATEXT && bus.shift_valid), .add_byte(byte0),
    .sub(1'b0), .sub_val('0),
    .acc(mat_acc), .ovf(mat_ovf)
  );

  // End of the literal run: block end means done, otherwise a match must follow.
  function automatic lz4_state_e post_lit(input logic [LEN_W-1:0] left);
    return (left == '0) ? ST_DONE : ST_OFFSET;
  endfunction

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= ST_IDLE;
      blk_size_q <= '0;
      consumed   <= '0;
      offset_q   <= '0;
      mnib       <= 4'h0;
      lit_hold   <= 1'b0;
      lit_k_q    <= 3'd0;
      done_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      lit_hold <= bus.lit_valid && !bus.lit_ready;
      lit_k_q  <= k_eff;
      if (bus.shift_valid) consumed <= consumed + LEN_W'(shift_n);
      case (state)
        ST_IDLE, ST_DONE, ST_ERR:
          if (bus.blk_start) begin
            blk_size_q <= bus.blk_size;
            consumed   <= '0;
            state      <= ST_TOKEN;
          end
        ST_TOKEN:
          if (remaining == '0) state <= ST_ERR;
          else if (bus.shift_valid) begin
            mnib <= byte0[3:0];
            if (byte0[7:4] == NIB_EXT) state <= ST_LITEXT;
            else if (byte0[7:4] != 4'h0) state <= ST_LIT;
            else begin
              state  <= post_lit(rem_after1);
              done_q <= rem_after1 == '0;
            end
          end
        ST_LITEXT:
          if (remaining == '0 || (bus.shift_valid && lit_ovf)) state <= ST_ERR;
          else if (bus.shift_valid && byte0 != LZ4_EXT_BYTE) state <= ST_LIT;
        ST_LIT:
          if (lit_too_long) state <= ST_ERR;
          else if (lit_xfer && lit_acc == LEN_W'(k_eff)) begin
            state  <= post_lit(rem_after_k);
            done_q <= rem_after_k == '0;
          end
        ST_OFFSET:
          if (remaining < LEN_W'(2)) state <= ST_ERR;
          else if (bus.shift_valid) begin
            offset_q <= {byte1, byte0};
            if ({byte1, byte0} == 16'h0) state <= ST_ERR;
            else if (mnib == NIB_EXT) state <= ST_MATEXT;
            else state <= ST_CMD;
          end
        ST_MATEXT:
          if (remaining == '0 || (bus.shift_valid && mat_ovf)) state <= ST_ERR;
          else if (bus.shift_valid && byte0 != LZ4_EXT_BYTE) state <= ST_CMD;
        ST_CMD:
          if (bus.mat_ready) state <= (remaining == '0) ? ST_ERR : ST_TOKEN;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
